// File: rtl/mem_lsu.sv
// Memory-access stage: multi-cycle req/gnt/rvalid data-memory handshake, ALU passthrough,
// one registered write-back result. Optional misalignment trap via LSU_MISALIGN_TRAP_EN.
module mem_lsu #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [4:0]      ex_mem_op,
  input  logic [4:0]      ex_rd,
  input  logic            ex_rf_wen,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_rf_wen,
  output logic            wb_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            st_q, st_d, uns_q, uns_d, wen_q, wen_d;
  logic [1:0]      size_q, size_d;
  logic [2:0]      off_q, off_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [7:0]      mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_rf_wen_q, wb_rf_wen_d, wb_err_q, wb_err_d;
  logic [7:0]      wmask_base;
  logic [XLEN-1:0] ld_sh, ld_ext;

  assign ex_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_REQ);
  assign wb_valid  = (state_q == S_DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_rf_wen = wb_rf_wen_q;
  assign wb_err    = wb_err_q;

  always_comb begin
    case (ex_mem_op[1:0])
      2'd0:    wmask_base = 8'h01;
      2'd1:    wmask_base = 8'h03;
      2'd2:    wmask_base = 8'h0F;
      default: wmask_base = 8'hFF;
    endcase
  end

  always_comb begin
    ld_sh = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld_ext = uns_q ? {56'd0, ld_sh[7:0]}  : {{56{ld_sh[7]}},  ld_sh[7:0]};
      2'd1:    ld_ext = uns_q ? {48'd0, ld_sh[15:0]} : {{48{ld_sh[15]}}, ld_sh[15:0]};
      2'd2:    ld_ext = uns_q ? {32'd0, ld_sh[31:0]} : {{32{ld_sh[31]}}, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    case (ex_mem_op[1:0])
      2'd1:    misalign = ex_addr[0];
      2'd2:    misalign = |ex_addr[1:0];
      2'd3:    misalign = |ex_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    uns_d       = uns_q;
    wen_d       = wen_q;
    size_d      = size_q;
    off_d       = off_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_rf_wen_d = wb_rf_wen_q;
    wb_err_d    = wb_err_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          st_d     = ex_mem_op[3];
          uns_d    = ex_mem_op[2];
          size_d   = ex_mem_op[1:0];
          off_d    = ex_addr[2:0];
          wen_d    = ex_rf_wen;
          wb_rd_d  = ex_rd;
          wb_err_d = 1'b0;
          if (!ex_mem_op[4]) begin
            wb_data_d   = ex_alu_result;
            wb_rf_wen_d = ex_rf_wen;
            state_d     = S_DONE;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (misalign) begin
            wb_data_d   = ex_addr;
            wb_rf_wen_d = 1'b0;
            wb_err_d    = 1'b1;
            state_d     = S_DONE;
`endif
          end else begin
            mem_we_d    = ex_mem_op[3];
            mem_addr_d  = {ex_addr[XLEN-1:3], 3'b000};
            mem_wdata_d = ex_wdata << {ex_addr[2:0], 3'b000};
            mem_wmask_d = wmask_base << ex_addr[2:0];
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        // rvalid coincident with gnt belongs to no outstanding load and is dropped
        if (mem_gnt) begin
          cnt_d = '0;
          if (st_q) begin
            wb_data_d   = '0;
            wb_rf_wen_d = 1'b0;
            state_d     = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_rvalid) begin
          wb_data_d   = ld_ext;
          wb_rf_wen_d = wen_q;
          state_d     = S_DONE;
        end else if (TIMEOUT != 0 && cnt_q + 32'd1 == TIMEOUT) begin
          wb_data_d   = '0;
          wb_rf_wen_d = 1'b0;
          wb_err_d    = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      st_q        <= 1'b0;
      uns_q       <= 1'b0;
      wen_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_rf_wen_q <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      uns_q       <= uns_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      off_q       <= off_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_rf_wen_q <= wb_rf_wen_d;
      wb_err_q    <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed and randomized ops checked against a byte-lane reference model.
module tb_mem_lsu;

  localparam int unsigned TMO = 4;

  logic        clk, rst;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_alu_result, ex_addr, ex_wdata;
  logic [4:0]  ex_mem_op, ex_rd;
  logic        ex_rf_wen;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        wb_valid, wb_ready, wb_rf_wen, wb_err;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  mem_lsu #(.XLEN(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_result(ex_alu_result),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_mem_op(ex_mem_op), .ex_rd(ex_rd),
    .ex_rf_wen(ex_rf_wen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_rf_wen(wb_rf_wen), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [1:0] sz, input logic uns);
    int unsigned nbits;
    logic [63:0] r, m;
    nbits = 8 << sz;
    r = rdata >> (off * 8);
    m = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
    r = r & m;
    if (!uns && nbits < 64 && r[nbits-1]) r = r | ~m;
    return r;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [2:0] off, input logic [1:0] sz);
    logic [15:0] w;
    w = ((16'd1 << (1 << sz)) - 16'd1) << off;
    return w[7:0];
  endfunction

  // Called right after a falling edge with the DUT idle; returns in the same situation.
  task automatic run_op(input logic is_mem, input logic st, input logic uns, input logic [1:0] sz,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] alu,
                        input logic [4:0] rd, input logic wen, input int unsigned gd,
                        input int unsigned rvd, input int unsigned wbd,
                        input logic [63:0] rdata, input logic coinc);
    logic [2:0] off;
    logic trap, tmo;
    logic [63:0] e_data;
    logic e_wen, e_err;
    int unsigned nw;
    off  = addr[2:0];
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = is_mem && ((off % (1 << sz)) != 0);
`endif
    tmo = is_mem && !st && !trap && (rvd >= TMO);
    if (!is_mem)      begin e_data = alu;   e_wen = wen;  e_err = 1'b0; end
    else if (trap)    begin e_data = addr;  e_wen = 1'b0; e_err = 1'b1; end
    else if (st)      begin e_data = '0;    e_wen = 1'b0; e_err = 1'b0; end
    else if (tmo)     begin e_data = '0;    e_wen = 1'b0; e_err = 1'b1; end
    else              begin e_data = model_load(rdata, off, sz, uns); e_wen = wen; e_err = 1'b0; end

    check("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_addr = addr; ex_wdata = wd; ex_alu_result = alu;
    ex_mem_op = {is_mem, st, uns, sz}; ex_rd = rd; ex_rf_wen = wen;
    @(negedge clk);
    ex_valid = 1'b0; ex_addr = {$urandom, $urandom}; ex_wdata = {$urandom, $urandom};
    ex_alu_result = {$urandom, $urandom}; ex_mem_op = 5'($urandom); ex_rd = 5'($urandom);
    ex_rf_wen = 1'($urandom);

    if (is_mem && !trap) begin
      for (int i = 0; i <= int'(gd); i++) begin
        check("req_mem_req", 64'(mem_req), 64'd1);
        check("req_mem_we", 64'(mem_we), 64'(st));
        check("req_mem_addr", mem_addr, {addr[63:3], 3'b000});
        check("req_mem_wmask", 64'(mem_wmask), 64'(model_wmask(off, sz)));
        check("req_mem_wdata", mem_wdata, wd << (off * 8));
        check("req_ex_ready", 64'(ex_ready), 64'd0);
        check("req_wb_valid", 64'(wb_valid), 64'd0);
        mem_gnt    = (i == int'(gd));
        mem_rvalid = (i == int'(gd)) && coinc;
        mem_rdata  = ~rdata;
        @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!st) begin
        nw = tmo ? TMO : rvd + 1;
        for (int i = 0; i < int'(nw); i++) begin
          check("wait_mem_req", 64'(mem_req), 64'd0);
          check("wait_wb_valid", 64'(wb_valid), 64'd0);
          check("wait_ex_ready", 64'(ex_ready), 64'd0);
          mem_rvalid = !tmo && (i == int'(rvd));
          mem_rdata  = mem_rvalid ? rdata : ~rdata;
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
      end
    end

    for (int i = 0; i <= int'(wbd); i++) begin
      check("done_wb_valid", 64'(wb_valid), 64'd1);
      check("done_wb_data", wb_data, e_data);
      check("done_wb_rd", 64'(wb_rd), 64'(rd));
      check("done_wb_rf_wen", 64'(wb_rf_wen), 64'(e_wen));
      check("done_wb_err", 64'(wb_err), 64'(e_err));
      check("done_ex_ready", 64'(ex_ready), 64'd0);
      check("done_mem_req", 64'(mem_req), 64'd0);
      wb_ready   = (i == int'(wbd));
      mem_rvalid = 1'($urandom);
      mem_rdata  = {$urandom, $urandom};
      @(negedge clk);
    end
    wb_ready = 1'b0; mem_rvalid = 1'b0;
    check("after_wb_valid", 64'(wb_valid), 64'd0);
  endtask

  initial begin
    logic        r_mem, r_st, r_uns, r_coinc, r_wen;
    logic [1:0]  r_sz;
    int unsigned r_rvd;

    rst = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_addr = '0; ex_wdata = '0;
    ex_mem_op = '0; ex_rd = '0; ex_rf_wen = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_rf_wen", 64'(wb_rf_wen), 64'd0);
    check("rst_wb_err", 64'(wb_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed: non-mem, sb, lb/lbu, slow gnt + wb stall, timeout, coincident gnt/rvalid
    run_op(1'b0, 1'b0, 1'b0, 2'd0, 64'h40, 64'h0, 64'h1234, 5'd5, 1'b1, 0, 0, 0, 64'h0, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 2'd0, 64'h8000_0003, 64'hAB, 64'h0, 5'd3, 1'b1, 0, 0, 0, 64'h0, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 2'd0, 64'h1005, 64'h0, 64'h0, 5'd7, 1'b1, 0, 0, 0,
           64'h0000_8000_0000_0000, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 2'd0, 64'h1005, 64'h0, 64'h0, 5'd7, 1'b1, 0, 0, 0,
           64'h0000_8000_0000_0000, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 2'd2, 64'h2004, 64'h0, 64'h0, 5'd9, 1'b1, 3, 1, 2,
           64'h8765_4321_0FED_CBA9, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 2'd3, 64'h3000, 64'h0, 64'h0, 5'd10, 1'b1, 0, TMO, 1,
           64'h1111_2222_3333_4444, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 2'd1, 64'h4006, 64'h0, 64'h0, 5'd11, 1'b1, 1, 1, 0,
           64'hF00D_0000_0000_0000, 1'b1);
    run_op(1'b1, 1'b0, 1'b0, 2'd2, 64'h5002, 64'h0, 64'h0, 5'd12, 1'b1, 0, 0, 0,
           64'hCAFE_BABE_DEAD_BEEF, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 2'd3, 64'h6005, 64'h0102_0304_0506_0708, 64'h0, 5'd13, 1'b1,
           0, 0, 0, 64'h0, 1'b0);

    // reset mid-REQ: mem_req must drop without a clock edge
    ex_valid = 1'b1; ex_mem_op = 5'b10010; ex_addr = 64'h7000; ex_rd = 5'd1; ex_rf_wen = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rstreq_mem_req_before", 64'(mem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstreq_mem_req", 64'(mem_req), 64'd0);
    check("rstreq_ex_ready", 64'(ex_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // reset mid-WAIT, then a late rvalid must not be captured
    ex_valid = 1'b1; ex_mem_op = 5'b10011; ex_addr = 64'h7008; ex_rd = 5'd2;
    @(negedge clk);
    ex_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rstwait_mem_req", 64'(mem_req), 64'd0);
    check("rstwait_ex_ready_before", 64'(ex_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("rstwait_ex_ready", 64'(ex_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_wb_valid", 64'(wb_valid), 64'd0);
    check("late_rvalid_ex_ready", 64'(ex_ready), 64'd1);
    check("late_rvalid_wb_data", wb_data, 64'd0);

    for (int k = 0; k < 40; k++) begin
      r_mem   = ($urandom_range(0, 3) != 0);
      r_st    = 1'($urandom);
      r_uns   = 1'($urandom);
      r_wen   = 1'($urandom);
      r_sz    = 2'($urandom);
      r_coinc = ($urandom_range(0, 4) == 0);
      r_rvd   = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 2);
      run_op(r_mem, r_st, r_uns, r_sz, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 5'($urandom), r_wen, $urandom_range(0, 3), r_rvd,
             $urandom_range(0, 2), {$urandom, $urandom}, r_coinc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
